// File: rtl/sram_sp_masked_init_ext_pkg.sv
// Shared definitions for the single-port masked SRAM model.
//   sweep_state_e : init-sweep FSM states
//   addr_width()  : address width derivation, never narrower than 1 bit
package sram_sp_masked_init_ext_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } sweep_state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        if (depth > 32'd1) w = int'($clog2(depth));
        else               w = 32'd1;
        return w;
    endfunction

endpackage

// File: rtl/sram_sp_masked_init_ext_if.sv
// RW0 access port bundle of the single-port SRAM.
//   master : drives addr/en/wmode/wmask/wdata, observes rdata/rvalid/init_busy
//   slave  : the memory side
interface sram_sp_masked_init_ext_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned WIDTH = 13,
    parameter int unsigned SEG   = 1
);
    logic [AW-1:0]    RW0_addr;
    logic             RW0_en;
    logic             RW0_wmode;
    logic [SEG-1:0]   RW0_wmask;
    logic [WIDTH-1:0] RW0_wdata;
    logic [WIDTH-1:0] RW0_rdata;
    logic             RW0_rvalid;
    logic             init_busy;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata, RW0_rvalid, init_busy
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata, RW0_rvalid, init_busy
    );
endinterface

// File: rtl/sram_sp_masked_init_ext_sweeper.sv
// Post-reset init sweep controller.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   busy_o        : high while the sweep runs (exactly DEPTH cycles)
//   sweep_we_o    : write strobe for the sweep
//   sweep_addr_o  : entry being cleared this cycle
module sram_sp_masked_init_ext_sweeper
    import sram_sp_masked_init_ext_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW      = 8,
    parameter bit          INIT_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          busy_o,
    output logic          sweep_we_o,
    output logic [AW-1:0] sweep_addr_o
);
    sweep_state_e  state_q;
    logic [AW-1:0] ptr_q;
    logic          busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if (INIT_EN) state_q <= ST_INIT;
            else         state_q <= ST_IDLE;
            ptr_q  <= '0;
            busy_q <= INIT_EN;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Last entry is written on this edge; busy falls with it.
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign sweep_we_o   = (state_q == ST_INIT);
    assign sweep_addr_o = ptr_q;
endmodule

// File: rtl/sram_sp_masked_init_ext.sv
// Single-port (RW0) behavioural SRAM with per-segment write mask, optional
// output register, read-valid strobe and hardware init sweep after reset.
//   RW0_clk : clock
//   reset   : asynchronous active-high reset (array contents are not reset)
//   rw0     : access port (addr, en, wmode, wmask, wdata -> rdata, rvalid, init_busy)
module sram_sp_masked_init_ext
    import sram_sp_masked_init_ext_pkg::*;
#(
    parameter int unsigned      DEPTH     = 256,
    parameter int unsigned      WIDTH     = 13,
    parameter int unsigned      MASK_GRAN = 13,
    parameter bit               OUT_REG   = 1'b0,
    parameter bit               INIT_EN   = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input  logic                      RW0_clk,
    input  logic                      reset,
    sram_sp_masked_init_ext_if.slave  rw0
);
    localparam int unsigned AW  = addr_width(DEPTH);
    localparam int unsigned SEG = WIDTH / MASK_GRAN;

    if (WIDTH % MASK_GRAN != 0) begin : g_gran_check
        $error("sram_sp_masked_init_ext: WIDTH must be a multiple of MASK_GRAN");
    end

    logic             busy;
    logic             sweep_we;
    logic [AW-1:0]    sweep_addr;

    sram_sp_masked_init_ext_sweeper #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .INIT_EN (INIT_EN)
    ) u_sweeper (
        .clk_i        (RW0_clk),
        .rst_i        (reset),
        .busy_o       (busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr)
    );

    logic [WIDTH-1:0] ram_q [DEPTH];

    logic             in_range;
    logic             user_wr;
    logic             rd_fire;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [SEG-1:0]   mem_mask;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] rd_data;

    assign in_range = (32'(rw0.RW0_addr) < DEPTH);
    assign user_wr  = rw0.RW0_en &&  rw0.RW0_wmode && !busy;
    assign rd_fire  = rw0.RW0_en && !rw0.RW0_wmode && !busy;
    assign rd_data  = in_range ? ram_q[rw0.RW0_addr] : '0;

    // Sweep owns the write port while it runs; user writes outside DEPTH are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = rw0.RW0_addr;
        mem_mask  = rw0.RW0_wmask;
        mem_wdata = rw0.RW0_wdata;
        if (sweep_we) begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr;
            mem_mask  = '1;
            mem_wdata = INIT_VAL;
        end else if (user_wr && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < SEG; i++) begin
                if (mem_mask[i])
                    ram_q[mem_addr][i*MASK_GRAN +: MASK_GRAN] <= mem_wdata[i*MASK_GRAN +: MASK_GRAN];
            end
        end
    end

    // Read data is captured at the read edge, so later writes cannot disturb it.
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_valid_q;

    always_ff @(posedge RW0_clk or posedge reset) begin
        if (reset) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) s1_data_q <= rd_data;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [WIDTH-1:0] s2_data_q;
        logic             s2_valid_q;

        always_ff @(posedge RW0_clk or posedge reset) begin
            if (reset) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) s2_data_q <= s1_data_q;
            end
        end

        assign rw0.RW0_rdata  = s2_data_q;
        assign rw0.RW0_rvalid = s2_valid_q;
    end else begin : g_no_out_reg
        assign rw0.RW0_rdata  = s1_data_q;
        assign rw0.RW0_rvalid = s1_valid_q;
    end

    assign rw0.init_busy = busy;
endmodule

// File: tb/tb_sram_sp_masked_init_ext.sv
// Directed self-checking bench for sram_sp_masked_init_ext.
//   dut_a : DEPTH=256, WIDTH=13, one segment, latency 1, INIT_VAL=13'h1AB
//   dut_b : DEPTH=200, WIDTH=16, two byte segments, latency 2, INIT_VAL=16'hC3C3
//   dut_c : DEPTH=16,  WIDTH=8,  two nibble segments, latency 1, no init sweep
module tb_sram_sp_masked_init_ext;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sram_sp_masked_init_ext_if #(.AW(8), .WIDTH(13), .SEG(1)) ia ();
    sram_sp_masked_init_ext_if #(.AW(8), .WIDTH(16), .SEG(2)) ib ();
    sram_sp_masked_init_ext_if #(.AW(4), .WIDTH(8),  .SEG(2)) ic ();

    sram_sp_masked_init_ext #(
        .DEPTH(256), .WIDTH(13), .MASK_GRAN(13), .OUT_REG(1'b0),
        .INIT_EN(1'b1), .INIT_VAL(13'h1AB)
    ) dut_a (.RW0_clk(clk), .reset(rst), .rw0(ia));

    sram_sp_masked_init_ext #(
        .DEPTH(200), .WIDTH(16), .MASK_GRAN(8), .OUT_REG(1'b1),
        .INIT_EN(1'b1), .INIT_VAL(16'hC3C3)
    ) dut_b (.RW0_clk(clk), .reset(rst), .rw0(ib));

    sram_sp_masked_init_ext #(
        .DEPTH(16), .WIDTH(8), .MASK_GRAN(4), .OUT_REG(1'b0),
        .INIT_EN(1'b0), .INIT_VAL(8'h00)
    ) dut_c (.RW0_clk(clk), .reset(rst), .rw0(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        ia.RW0_en = 1'b0; ia.RW0_wmode = 1'b0; ia.RW0_addr = '0; ia.RW0_wmask = '0; ia.RW0_wdata = '0;
        ib.RW0_en = 1'b0; ib.RW0_wmode = 1'b0; ib.RW0_addr = '0; ib.RW0_wmask = '0; ib.RW0_wdata = '0;
        ic.RW0_en = 1'b0; ic.RW0_wmode = 1'b0; ic.RW0_addr = '0; ic.RW0_wmask = '0; ic.RW0_wdata = '0;
    endtask

    task automatic test_reset();
        vectors++;
        if (ia.RW0_rdata !== 13'h0 || ia.RW0_rvalid !== 1'b0 || ia.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_a: rdata=%h rvalid=%b busy=%b expected 0 0 1", ia.RW0_rdata, ia.RW0_rvalid, ia.init_busy);
        end
        vectors++;
        if (ib.RW0_rdata !== 16'h0 || ib.RW0_rvalid !== 1'b0 || ib.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_b: rdata=%h rvalid=%b busy=%b expected 0 0 1", ib.RW0_rdata, ib.RW0_rvalid, ib.init_busy);
        end
        vectors++;
        if (ic.RW0_rdata !== 8'h0 || ic.RW0_rvalid !== 1'b0 || ic.init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c: rdata=%h rvalid=%b busy=%b expected 0 0 0", ic.RW0_rdata, ic.RW0_rvalid, ic.init_busy);
        end
    endtask

    task automatic test_init_sweep();
        int cnt_a = 0;
        int cnt_b = 0;
        rst = 1'b0;
        for (int n = 0; n < 400 && (ia.init_busy || ib.init_busy); n++) begin
            if (ia.init_busy) cnt_a++;
            if (ib.init_busy) cnt_b++;
            @(negedge clk);
        end
        vectors++;
        if (cnt_a != 256) begin
            miscompares++;
            $display("FAIL sweep_len_a: busy cycles=%0d expected 256", cnt_a);
        end
        vectors++;
        if (cnt_b != 200) begin
            miscompares++;
            $display("FAIL sweep_len_b: busy cycles=%0d expected 200", cnt_b);
        end
        // read addr 0 then addr 255 back to back
        ia.RW0_en = 1'b1; ia.RW0_wmode = 1'b0; ia.RW0_addr = 8'd0;
        @(negedge clk);
        vectors++;
        if (ia.RW0_rdata !== 13'h1AB || ia.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL init_rd0: rdata=%h rvalid=%b expected 1ab 1", ia.RW0_rdata, ia.RW0_rvalid);
        end
        ia.RW0_addr = 8'd255;
        @(negedge clk);
        ia.RW0_en = 1'b0;
        vectors++;
        if (ia.RW0_rdata !== 13'h1AB || ia.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL init_rd255: rdata=%h rvalid=%b expected 1ab 1", ia.RW0_rdata, ia.RW0_rvalid);
        end
        @(negedge clk);
        vectors++;
        if (ia.RW0_rdata !== 13'h1AB || ia.RW0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL init_hold: rdata=%h rvalid=%b expected 1ab 0", ia.RW0_rdata, ia.RW0_rvalid);
        end
    endtask

    task automatic test_masked_write();
        logic [15:0] wd [3] = '{16'hAAAA, 16'h5555, 16'h1234};
        logic [1:0]  wm [3] = '{2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 3; k++) begin
            ib.RW0_en = 1'b1; ib.RW0_wmode = 1'b1; ib.RW0_addr = 8'd5;
            ib.RW0_wdata = wd[k]; ib.RW0_wmask = wm[k];
            @(negedge clk);
        end
        ib.RW0_wmode = 1'b0;
        @(negedge clk);
        ib.RW0_en = 1'b0;
        vectors++;
        if (ib.RW0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_latency: rvalid=%b expected 0 one cycle after read", ib.RW0_rvalid);
        end
        @(negedge clk);
        vectors++;
        if (ib.RW0_rdata !== 16'hAA55 || ib.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_rd5: rdata=%h rvalid=%b expected aa55 1", ib.RW0_rdata, ib.RW0_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d;
        for (int k = 1; k <= 3; k++) begin
            ib.RW0_en = 1'b1; ib.RW0_wmode = 1'b1; ib.RW0_wmask = 2'b11;
            ib.RW0_addr = 8'(k); ib.RW0_wdata = 16'(k);
            @(negedge clk);
        end
        for (int k = 0; k < 7; k++) begin
            if (k < 3) begin
                ib.RW0_en = 1'b1; ib.RW0_wmode = 1'b0; ib.RW0_addr = 8'(k + 1);
            end else begin
                ib.RW0_en = 1'b0;
            end
            @(negedge clk);
            if (k == 0)      exp_d = 16'hAA55;
            else if (k <= 3) exp_d = 16'(k);
            else             exp_d = 16'd3;
            vectors++;
            if (ib.RW0_rdata !== exp_d || ib.RW0_rvalid !== (k >= 1 && k <= 3)) begin
                miscompares++;
                $display("FAIL b2b_step%0d: rdata=%h rvalid=%b expected %h %b",
                         k, ib.RW0_rdata, ib.RW0_rvalid, exp_d, (k >= 1 && k <= 3));
            end
        end
    endtask

    task automatic test_depth_bound();
        ib.RW0_en = 1'b1; ib.RW0_wmode = 1'b1; ib.RW0_wmask = 2'b11;
        ib.RW0_addr = 8'd210; ib.RW0_wdata = 16'h0007;
        @(negedge clk);
        ib.RW0_wmode = 1'b0;
        @(negedge clk);
        ib.RW0_addr = 8'd199;
        @(negedge clk);
        ib.RW0_en = 1'b0;
        vectors++;
        if (ib.RW0_rdata !== 16'h0000 || ib.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_rd210: rdata=%h rvalid=%b expected 0000 1", ib.RW0_rdata, ib.RW0_rvalid);
        end
        @(negedge clk);
        vectors++;
        if (ib.RW0_rdata !== 16'hC3C3 || ib.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_rd199: rdata=%h rvalid=%b expected c3c3 1", ib.RW0_rdata, ib.RW0_rvalid);
        end
    endtask

    task automatic test_read_then_write();
        ia.RW0_en = 1'b1; ia.RW0_wmode = 1'b1; ia.RW0_wmask = 1'b1;
        ia.RW0_addr = 8'd7; ia.RW0_wdata = 13'd9;
        @(negedge clk);
        ia.RW0_wmode = 1'b0;
        @(negedge clk);
        vectors++;
        if (ia.RW0_rdata !== 13'd9 || ia.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rtw_rd9: rdata=%h rvalid=%b expected 009 1", ia.RW0_rdata, ia.RW0_rvalid);
        end
        ia.RW0_wmode = 1'b1; ia.RW0_wdata = 13'd4;
        @(negedge clk);
        vectors++;
        if (ia.RW0_rdata !== 13'd9 || ia.RW0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL rtw_hold: rdata=%h rvalid=%b expected 009 0", ia.RW0_rdata, ia.RW0_rvalid);
        end
        ia.RW0_wmode = 1'b0;
        @(negedge clk);
        ia.RW0_en = 1'b0;
        vectors++;
        if (ia.RW0_rdata !== 13'd4 || ia.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rtw_rd4: rdata=%h rvalid=%b expected 004 1", ia.RW0_rdata, ia.RW0_rvalid);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt_a = 0;
        rst = 1'b1;
        #1;
        vectors++;
        if (ia.RW0_rdata !== 13'h0 || ia.RW0_rvalid !== 1'b0 || ia.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL async_rst: rdata=%h rvalid=%b busy=%b expected 0 0 1", ia.RW0_rdata, ia.RW0_rvalid, ia.init_busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        vectors++;
        if (ia.init_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_busy: busy=%b expected 1 at ptr 100", ia.init_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 400 && ia.init_busy; n++) begin
            cnt_a++;
            vectors++;
            if (ia.RW0_rvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_rvalid: rvalid=%b expected 0 at busy cycle %0d", ia.RW0_rvalid, n);
            end
            ia.RW0_en = 1'b1; ia.RW0_wmode = (n % 2 == 0); ia.RW0_addr = 8'd7;
            ia.RW0_wmask = 1'b1; ia.RW0_wdata = 13'h0AA;
            @(negedge clk);
        end
        ia.RW0_en = 1'b0;
        vectors++;
        if (cnt_a != 256 || ia.RW0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL resweep_len: busy cycles=%0d rvalid=%b expected 256 0", cnt_a, ia.RW0_rvalid);
        end
        ia.RW0_en = 1'b1; ia.RW0_wmode = 1'b0; ia.RW0_addr = 8'd7;
        @(negedge clk);
        ia.RW0_en = 1'b0;
        vectors++;
        if (ia.RW0_rdata !== 13'h1AB || ia.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL resweep_rd7: rdata=%h rvalid=%b expected 1ab 1", ia.RW0_rdata, ia.RW0_rvalid);
        end
    endtask

    task automatic test_no_init();
        ic.RW0_en = 1'b1; ic.RW0_wmode = 1'b1; ic.RW0_wmask = 2'b11;
        ic.RW0_addr = 4'd3; ic.RW0_wdata = 8'hA5;
        @(negedge clk);
        ic.RW0_wmode = 1'b0;
        @(negedge clk);
        vectors++;
        if (ic.RW0_rdata !== 8'hA5 || ic.RW0_rvalid !== 1'b1 || ic.init_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL noinit_rd: rdata=%h rvalid=%b busy=%b expected a5 1 0", ic.RW0_rdata, ic.RW0_rvalid, ic.init_busy);
        end
        ic.RW0_wmode = 1'b1; ic.RW0_wmask = 2'b10; ic.RW0_wdata = 8'h3C;
        @(negedge clk);
        ic.RW0_wmode = 1'b0;
        @(negedge clk);
        ic.RW0_en = 1'b0;
        vectors++;
        if (ic.RW0_rdata !== 8'h35 || ic.RW0_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL noinit_mask: rdata=%h rvalid=%b expected 35 1", ic.RW0_rdata, ic.RW0_rvalid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_all();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_init_sweep();
        test_masked_write();
        test_back_to_back();
        test_depth_bound();
        test_read_then_write();
        test_reset_mid_sweep();
        test_no_init();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
